// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, optional parity, break detection.
// Line decisions use the synchronised copy of i_rx; outputs are registered.
module uart_rx #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_baud_x16,
  input  logic                 i_rx,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   par_err_q, par_err_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   busy_q, busy_d;

  // Line synchroniser; resets to the idle (high) level.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_err_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      par_err_q    <= par_err_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
    end
  end

  // Everything except the valid pulse only moves on a baud tick.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    par_err_d    = par_err_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;

    if (i_baud_x16) begin
      cnt_d = cnt_q + CNT_W'(1);
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = S_START;
            par_en_d  = i_parity_en;
            par_odd_d = i_parity_odd;
            par_err_d = 1'b0;
            bit_d     = '0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_W'(7)) begin
            cnt_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_W'(15)) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
              state_d = par_en_q ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (cnt_q == CNT_W'(15)) begin
            par_err_d = (^shift_q) ^ rx_s ^ par_odd_q;
            state_d   = S_STOP;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_W'(15)) begin
            valid_d      = 1'b1;
            data_d       = shift_q;
            frame_err_d  = ~rx_s;
            parity_err_d = par_en_q & par_err_q;
            state_d      = rx_s ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = frame_err_q;
  assign o_parity_err = parity_err_q;
  assign o_busy       = busy_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning: number of data bits per frame, legal range 5..8.
REQ-002 Parameter SYNC_STAGES, default 2, meaning: flip-flop stages in the i_rx synchroniser, minimum 2.
REQ-003 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 i_rstn  input  1  asynchronous, active-low reset.
REQ-005 i_baud_x16  input  1  one-i_clk-wide pulse at 16x the baud rate, from the baud generator.
REQ-006 i_rx  input  1  asynchronous serial line, idle high.
REQ-007 i_parity_en  input  1  1 = a parity bit follows the data bits.
REQ-008 i_parity_odd  input  1  1 = odd parity, 0 = even parity; ignored when i_parity_en = 0.
REQ-009 o_data  output  DATA_BITS  last received data word, LSB received first.
REQ-010 o_valid  output  1  one-i_clk pulse; o_data and the error flags are valid in that cycle.
REQ-011 o_frame_err  output  1  stop bit sampled low; qualified by o_valid.
REQ-012 o_parity_err  output  1  parity mismatch; qualified by o_valid; 0 when parity is disabled.
REQ-013 o_busy  output  1  high in every state except IDLE.

Function
REQ-014 i_rx SHALL pass through SYNC_STAGES flip-flops reset to 1; all line decisions use the synchronised value (rx_s).
REQ-015 The 4-bit tick counter SHALL advance only on cycles where i_baud_x16 = 1 and SHALL wrap from 15 to 0.
REQ-016 States: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-017 IDLE: on a tick with rx_s = 0 -> START with counter = 0; otherwise the counter holds at 0.
REQ-018 START: on the tick where counter = 7 (mid-bit), rx_s = 0 -> DATA with counter = 0; rx_s = 1 -> IDLE (glitch rejected, no o_valid).
REQ-019 DATA: sample rx_s on each tick where counter = 15 (16 ticks after the previous sample), shifting LSB-first.
REQ-020 DATA: after DATA_BITS samples -> PARITY if i_parity_en = 1, else STOP.
REQ-021 PARITY: sample at counter = 15; error = XOR(data bits, parity bit, i_parity_odd) != 0; -> STOP.
REQ-022 i_parity_en and i_parity_odd SHALL be sampled when leaving IDLE and held for the whole frame.
REQ-023 STOP: sample at counter = 15; on the next i_clk, o_valid = 1 for exactly one cycle, o_data and o_parity_err are updated, and o_frame_err = NOT stop sample.
REQ-024 STOP, stop bit = 1: -> IDLE immediately, so a back-to-back start edge half a bit later is accepted.
REQ-025 STOP, stop bit = 0: -> BREAK; BREAK -> IDLE on the first tick with rx_s = 1; no new frame starts while the line stays low.
REQ-026 o_data and both error flags SHALL hold their values until the next o_valid.
REQ-027 There is no backpressure; an unconsumed o_valid is lost and receive timing is never stalled.
REQ-028 Cycles without i_baud_x16 SHALL NOT change the state or the counter, except the o_valid pulse and the synchroniser shift.

Reset
REQ-029 While i_rstn = 0: state = IDLE, counter = 0, shift register = 0, synchroniser = all 1, o_data = 0, o_valid = 0, o_frame_err = 0, o_parity_err = 0, o_busy = 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no o_valid; reception resumes from IDLE on the first start edge after release.

Verification
REQ-031 Tick every 4 clocks (64 clocks per bit), parity off, send 0xA5 with stop = 1 -> one o_valid, o_data = 0xA5, both error flags 0, o_busy low afterwards.
REQ-032 Two back-to-back frames 0x00 then 0xFF with no idle gap -> two o_valid pulses with o_data 0x00 then 0xFF, no errors.
REQ-033 Line-low glitch of 3 ticks while IDLE -> return to IDLE, no o_valid, o_busy high only during the glitch window.
REQ-034 Even parity enabled, send 0x03 with parity bit 1 -> o_parity_err = 1; repeat with parity bit 0 -> o_parity_err = 0; repeat with odd parity and parity bit 1 -> o_parity_err = 0.
REQ-035 Send 0x55 with stop = 0, hold line low for 40 bit times, then high -> one o_valid with o_frame_err = 1, no further o_valid until the line is high, then 0x5A is received correctly.
REQ-036 Assert i_rstn = 0 during the 4th data bit -> all outputs at reset values; the next full frame 0x3C is received correctly.
